// File: rtl/fetch_queue.sv
// In-order DEPTH-entry bundle FIFO between IFU and decode; 1-cycle fetch-to-decode latency, stall asserted while full.
// Optional FETCH_QUEUE_BYPASS_EN forwards an incoming bundle straight to decode when the queue is empty (0-cycle latency).
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module fetch_queue #(
  parameter int FETCH_WIDTH     = `FETCH_WIDTH,
  parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             new_valid_inst,
  input  logic [32*FETCH_WIDTH-1:0]        Instruction_Code,
  input  logic [INST_ADDR_WIDTH-1:0]       pc_in,
  input  logic                             seen_last_inst,
  input  logic                             flush,
  output logic                             stall,
  input  logic                             dec_ready,
  output logic                             dec_valid,
  output logic [32*FETCH_WIDTH-1:0]        dec_inst,
  output logic [INST_ADDR_WIDTH-1:0]       dec_pc,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic                             drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = 32*FETCH_WIDTH;
  localparam logic [31:0]   NOP_WORD   = {25'b0, 7'b0010011};
  localparam logic [DW-1:0] NOP_BUNDLE = {FETCH_WIDTH{NOP_WORD}};
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, LAST, DONE} state_t;

  logic [DW-1:0]              inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  state_t                     state;

  logic full, empty, accept, bypass, push, pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = new_valid_inst & ~full & ~flush & (state != DONE);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept & empty & dec_ready;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed bundle is consumed directly, so it is neither written nor popped.
  assign push      = accept & ~bypass;
  assign pop       = ~empty & ~flush & dec_ready;
  assign dec_valid = (~empty & ~flush) | bypass;
  assign stall     = full;
  assign occupancy = count;

  always_comb begin
    dec_inst = NOP_BUNDLE;
    dec_pc   = '0;
    if (bypass) begin
      dec_inst = Instruction_Code;
      dec_pc   = pc_in;
    end else if (dec_valid) begin
      dec_inst = inst_mem[rd_ptr];
      dec_pc   = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= Instruction_Code;
      pc_mem[wr_ptr]   <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // End-of-program tracking; LAST ignores flush and waits for an empty, idle cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN: if (seen_last_inst) state <= LAST;
        LAST: if (empty && !accept) begin
          state   <= DONE;
          drained <= 1'b1;
        end
        DONE: state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int FW    = 2;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [32*FW-1:0] NOP_B = {FW{32'h0000_0013}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic new_valid_inst = 1'b0;
  logic seen_last_inst = 1'b0;
  logic flush = 1'b0;
  logic dec_ready = 1'b0;
  logic [32*FW-1:0] Instruction_Code = '0;
  logic [AW-1:0] pc_in = '0;
  logic stall, dec_valid, drained;
  logic [32*FW-1:0] dec_inst;
  logic [AW-1:0] dec_pc;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [32*FW-1:0] inst;
    logic [AW-1:0]    pc;
  } ent_t;
  ent_t q[$];
  bit last_f = 0;
  bit done_f = 0;

  fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .new_valid_inst(new_valid_inst),
    .Instruction_Code(Instruction_Code), .pc_in(pc_in),
    .seen_last_inst(seen_last_inst), .flush(flush), .stall(stall),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .occupancy(occupancy), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit nv, input logic [AW-1:0] pc, input bit seen,
                      input bit fl, input bit rdy);
    bit full, byp, vld, take, go_done;
    int size;
    ent_t head, inc;
    @(negedge clk);
    for (int l = 0; l < FW; l++) Instruction_Code[32*l +: 32] = $urandom;
    new_valid_inst = nv;
    pc_in = pc;
    seen_last_inst = seen;
    flush = fl;
    dec_ready = rdy;
    #1;
    inc.inst = Instruction_Code;
    inc.pc = pc;
    size = q.size();
    full = (size == DEPTH);
    byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (size == 0) && nv && rdy && !fl && !done_f;
`endif
    vld = ((size != 0) && !fl) || byp;
    if (byp) head = inc;
    else if (vld) head = q[0];
    else begin
      head.inst = NOP_B;
      head.pc = '0;
    end
    chk("stall", 128'(stall), 128'(full));
    chk("dec_valid", 128'(dec_valid), 128'(vld));
    chk("dec_inst", 128'(dec_inst), 128'(head.inst));
    chk("dec_pc", 128'(dec_pc), 128'(head.pc));
    chk("occupancy", 128'(occupancy), 128'(size));
    chk("drained", 128'(drained), 128'(done_f));
    take = nv && !full && !fl && !done_f;
    go_done = last_f && (size == 0) && !take;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (vld && rdy && !byp) void'(q.pop_front());
      if (take && !byp) q.push_back(inc);
    end
    if (seen) last_f = 1;
    if (go_done) done_f = 1;
  endtask

  // Reset is asserted mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    @(negedge clk);
    new_valid_inst = 0;
    flush = 0;
    seen_last_inst = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_valid", 128'(dec_valid), 128'(0));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_drained", 128'(drained), 128'(0));
    chk("rst_inst", 128'(dec_inst), 128'(NOP_B));
    chk("rst_pc", 128'(dec_pc), 128'(0));
    q.delete();
    last_f = 0;
    done_f = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    do_reset();
    // Fill to full, then an extra valid that must be ignored.
    for (int i = 0; i < 4; i++) step(1, AW'(4*i), 0, 0, 0);
    step(1, AW'(16), 0, 0, 0);
    // Drain in order.
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 1);
    // Steady state at occupancy 2 with simultaneous push/pop, pointers wrap.
    step(1, AW'('h18), 0, 0, 0);
    step(1, AW'('h1c), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, AW'('h20 + 4*i), 0, 0, 1);
    // Flush with occupancy 3 and a same-cycle push.
    step(1, AW'('h38), 0, 0, 0);
    step(1, AW'('h99), 0, 1, 0);
    step(1, AW'('h100), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // Bypass / single-cycle latency case on an empty queue.
    step(1, AW'('h40), 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // End-of-program drain with two entries held.
    step(1, AW'('h200), 0, 0, 0);
    step(1, AW'('h204), 0, 0, 0);
    step(0, '0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, AW'('h300 + 4*i), 0, 0, 1);
    // Mid-operation reset with contents held.
    step(1, AW'('h400), 0, 0, 0);
    step(1, AW'('h404), 0, 0, 0);
    do_reset();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(9) < 7, AW'($urandom) & ~AW'(3),
                $urandom_range(199) == 0, $urandom_range(19) == 0,
                $urandom_range(9) < 6);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
